uart_cmd_assembler: RTL and testbench
=====================================

// Module: uart_cmd_assembler
// PURPOSE
// Downstream of the UART receiver. Consumes bytes from UART_rcv (rdy/rx_data, clears them via clr_rdy).
// Assembles 3-byte command packets {cmd[7:0], data_hi[7:0], data_lo[7:0]} for the flight controller.
// Presents cmd/data with a cmd_rdy/clr_cmd_rdy handshake.
// Discards partial packets when an inter-byte timeout expires.
// PARAMETERS
// TIMEOUT_CYCLES  131072  max clk cycles between accepted bytes of one packet before abort (>=2)
// PORTS
// clk          in   1   system clock, all logic on posedge
// rst          in   1   synchronous, active-high reset
// rx_rdy       in   1   UART_rcv rdy: byte valid on rx_data
// rx_data      in   8   UART_rcv received byte
// clr_rx_rdy   out  1   to UART_rcv clr_rdy: combinational, high in the cycle a byte is accepted
// cmd          out  8   command byte of last complete packet
// data         out  16  {data_hi,data_lo} of last complete packet
// cmd_rdy      out  1   complete packet available on cmd/data
// clr_cmd_rdy  in   1   consumer acknowledge, clears cmd_rdy
// overrun      out  1   1-cycle pulse: packet completed while cmd_rdy was still 1
// frame_err    out  1   1-cycle pulse: partial packet discarded on timeout
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, cmd=0, data=0, cmd_rdy=0, overrun=0, frame_err=0, timer=0, shadow regs=0.
// - clr_rx_rdy = rx_rdy. It is 0 while rst=1, else it equals rx_rdy.
// - A byte is accepted in every cycle rx_rdy=1. UART_rcv drops rdy the next cycle, so no double capture.
// - FSM:
//   - IDLE: on accept, cmd_sh<=rx_data, go HIGH.
//   - HIGH: on accept, hi_sh<=rx_data, go LOW.
//   - LOW: on accept, cmd<=cmd_sh, data<={hi_sh,rx_data}, cmd_rdy<=1, go IDLE.
// - Latency: cmd/data/cmd_rdy update on the posedge that samples rx_rdy=1 for the third byte. They are visible next cycle.
// - cmd/data are output registers and hold the last complete packet. Partial packets never disturb them.
// - cmd_rdy:
//   - Set on packet completion.
//   - Cleared on clr_cmd_rdy=1.
//   - If completion and clr_cmd_rdy occur in the same cycle, completion wins (cmd_rdy=1, no overrun).
//   - cmd_rdy is NOT cleared by the start of a new packet.
// - overrun: pulses 1 cycle when a packet completes with cmd_rdy=1 and clr_cmd_rdy=0. New values overwrite cmd/data.
// - Timeout:
//   - timer is $clog2(TIMEOUT_CYCLES+1) bits. It is cleared on every accept and in IDLE.
//   - In HIGH/LOW it increments each cycle without accept.
//   - When timer==TIMEOUT_CYCLES-1 and no accept, go IDLE, clear timer, and pulse frame_err.
//   - Byte accept in the same cycle as expiry: accept wins, no frame_err.
//   - The byte after a timeout is treated as a new cmd byte.
// - Mid-packet rst: partial packet dropped, outputs to reset values, no frame_err.
// - Timer saturates logic-wise; no wrap possible since expiry forces IDLE.
// TESTING
// 1. Reset, then bytes 0x02,0x12,0x34 on rx_rdy pulses -> clr_rx_rdy mirrors each rx_rdy; cmd=0x02, data=0x1234, cmd_rdy=1 one cycle after third accept.
// 2. With cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle; cmd/data hold 0x02/0x1234.
// 3. TIMEOUT_CYCLES=1000: send 0x05,0xAA, then idle 1000 cycles -> frame_err pulses exactly 1 cycle; then 0x07,0x00,0x01 -> cmd=0x07, data=0x0001.
// 4. Second packet 0x09,0xBE,0xEF without clr_cmd_rdy -> overrun 1-cycle pulse, cmd=0x09, data=0xBEEF, cmd_rdy=1.
// 5. Packet completion with clr_cmd_rdy=1 same cycle -> cmd_rdy=1, overrun=0. Third byte exactly at timer expiry -> packet completes, frame_err=0.
// 6. Integrated with UART_tx->UART_rcv: transmit 0x6A,0x3C,0xC3 -> cmd=0x6A, data=0x3CC3; rst asserted after the 2nd byte -> cmd_rdy stays 0.

Source files
------------

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / command-out handshake bundle between UART_rcv, the packet assembler
// and the flight-controller consumer.
interface uart_cmd_assembler_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        overrun;
    logic        frame_err;

    modport master (
        input  rx_rdy, rx_data, clr_cmd_rdy,
        output clr_rx_rdy, cmd, data, cmd_rdy, overrun, frame_err
    );

    modport slave (
        output rx_rdy, rx_data, clr_cmd_rdy,
        input  clr_rx_rdy, cmd, data, cmd_rdy, overrun, frame_err
    );
endinterface

// File: rtl/uart_cmd_assembler.sv
// Assembles 3-byte {cmd, data_hi, data_lo} packets from UART_rcv bytes, with an
// inter-byte timeout that discards partial packets.
module uart_cmd_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 131072
) (
    input logic                   clk,
    input logic                   rst,
    uart_cmd_assembler_if.master  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_e;

    state_e        state_q;
    logic [7:0]    cmd_sh_q;
    logic [7:0]    hi_sh_q;
    logic [7:0]    cmd_q;
    logic [15:0]   data_q;
    logic          cmd_rdy_q;
    logic          overrun_q;
    logic          frame_err_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          accept;
    logic          expire;

    assign accept = bus.rx_rdy;

    always_comb begin
        timer_d = timer_q + TW'(1);
        expire  = (timer_q == TIMER_LAST) && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_sh_q    <= '0;
            hi_sh_q     <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            // Completion in LOW overrides this clear when both land together.
            if (bus.clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (accept) begin
                        cmd_sh_q <= bus.rx_data;
                        state_q  <= HIGH;
                    end
                end
                HIGH: begin
                    if (accept) begin
                        hi_sh_q <= bus.rx_data;
                        timer_q <= '0;
                        state_q <= LOW;
                    end else if (expire) begin
                        timer_q     <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                LOW: begin
                    if (accept) begin
                        cmd_q     <= cmd_sh_q;
                        data_q    <= {hi_sh_q, bus.rx_data};
                        cmd_rdy_q <= 1'b1;
                        overrun_q <= cmd_rdy_q && !bus.clr_cmd_rdy;
                        timer_q   <= '0;
                        state_q   <= IDLE;
                    end else if (expire) begin
                        timer_q     <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.clr_rx_rdy = bus.rx_rdy && !rst;
    assign bus.cmd        = cmd_q;
    assign bus.data       = data_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: directed vector table, timeout
// corner sequences, and randomized traffic against a packet-level model.
module tb_uart_cmd_assembler;

    localparam int unsigned TO = 1000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_cmd_assembler_if bus();

    uart_cmd_assembler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet-level reference: bytes collected so far and idle cycles since the last one.
    logic [7:0]  m_pkt[$];
    int          m_gap;
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    logic        m_rdy;
    logic        m_ovr;
    logic        m_fe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic c);
        logic was_rdy;
        if (r) begin
            m_pkt.delete();
            m_gap  = 0;
            m_cmd  = '0;
            m_data = '0;
            m_rdy  = 1'b0;
            m_ovr  = 1'b0;
            m_fe   = 1'b0;
        end else begin
            was_rdy = m_rdy;
            m_ovr   = 1'b0;
            m_fe    = 1'b0;
            if (c) m_rdy = 1'b0;
            if (v) begin
                m_pkt.push_back(d);
                m_gap = 0;
                if (m_pkt.size() == 3) begin
                    m_ovr  = was_rdy && !c;
                    m_cmd  = m_pkt[0];
                    m_data = {m_pkt[1], m_pkt[2]};
                    m_rdy  = 1'b1;
                    m_pkt.delete();
                end
            end else if (m_pkt.size() > 0) begin
                m_gap++;
                if (m_gap == int'(TO)) begin
                    m_pkt.delete();
                    m_gap = 0;
                    m_fe  = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        rst             = r;
        bus.rx_rdy      = v;
        bus.rx_data     = d;
        bus.clr_cmd_rdy = c;
        #1 chk("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(v & ~r));
        @(posedge clk);
        model_step(r, v, d, c);
        #1;
    endtask

    task automatic chk_model();
        chk("cmd",       32'(bus.cmd),       32'(m_cmd));
        chk("data",      32'(bus.data),      32'(m_data));
        chk("cmd_rdy",   32'(bus.cmd_rdy),   32'(m_rdy));
        chk("overrun",   32'(bus.overrun),   32'(m_ovr));
        chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
    endtask

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        c;
        logic [7:0]  e_cmd;
        logic [15:0] e_data;
        logic        e_rdy;
        logic        e_ovr;
        logic        e_fe;
    } vec_t;

    vec_t vecs[$];
    int   fe_cnt;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.rx_rdy = 1'b0;
        bus.rx_data = '0;
        bus.clr_cmd_rdy = 1'b0;
        m_pkt.delete();
        m_gap = 0; m_cmd = '0; m_data = '0; m_rdy = 0; m_ovr = 0; m_fe = 0;

        //            r  v  d      c  cmd    data      rdy ovr fe
        vecs.push_back('{1, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h02, 0, 8'h00, 16'h0000, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h12, 0, 8'h00, 16'h0000, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h34, 0, 8'h02, 16'h1234, 1, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 8'h02, 16'h1234, 1, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 1, 8'h02, 16'h1234, 0, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 8'h02, 16'h1234, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h33, 0, 8'h02, 16'h1234, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h44, 0, 8'h02, 16'h1234, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h55, 0, 8'h33, 16'h4455, 1, 0, 0});
        vecs.push_back('{0, 1, 8'h09, 0, 8'h33, 16'h4455, 1, 0, 0});
        vecs.push_back('{0, 1, 8'hBE, 0, 8'h33, 16'h4455, 1, 0, 0});
        vecs.push_back('{0, 1, 8'hEF, 0, 8'h09, 16'hBEEF, 1, 1, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 8'h09, 16'hBEEF, 1, 0, 0});
        vecs.push_back('{0, 1, 8'hA1, 0, 8'h09, 16'hBEEF, 1, 0, 0});
        vecs.push_back('{0, 1, 8'hB2, 0, 8'h09, 16'hBEEF, 1, 0, 0});
        vecs.push_back('{0, 1, 8'hC3, 1, 8'hA1, 16'hB2C3, 1, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 1, 8'hA1, 16'hB2C3, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h5A, 0, 8'hA1, 16'hB2C3, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h6B, 0, 8'hA1, 16'hB2C3, 0, 0, 0});
        vecs.push_back('{1, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h7C, 0, 8'h00, 16'h0000, 0, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h8D, 0, 8'h00, 16'h0000, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h9E, 0, 8'h7C, 16'h8D9E, 1, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].c);
            chk($sformatf("vec%0d.cmd", i),       32'(bus.cmd),       32'(vecs[i].e_cmd));
            chk($sformatf("vec%0d.data", i),      32'(bus.data),      32'(vecs[i].e_data));
            chk($sformatf("vec%0d.cmd_rdy", i),   32'(bus.cmd_rdy),   32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d.overrun", i),   32'(bus.overrun),   32'(vecs[i].e_ovr));
            chk($sformatf("vec%0d.frame_err", i), 32'(bus.frame_err), 32'(vecs[i].e_fe));
        end
        cyc(0, 0, 8'h00, 1);

        // Timeout in LOW: frame_err exactly once, on the TO-th idle cycle.
        cyc(0, 1, 8'h05, 0);
        cyc(0, 1, 8'hAA, 0);
        fe_cnt = 0;
        for (int i = 1; i <= int'(TO) + 2; i++) begin
            cyc(0, 0, 8'h00, 0);
            chk_model();
            if (bus.frame_err) begin
                fe_cnt++;
                chk("fe_position", 32'(i), 32'(TO));
            end
        end
        chk("fe_count_low", 32'(fe_cnt), 32'd1);
        cyc(0, 1, 8'h07, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h01, 0);
        chk("after_to.cmd", 32'(bus.cmd), 32'h07);
        chk("after_to.data", 32'(bus.data), 32'h0001);
        chk("after_to.rdy", 32'(bus.cmd_rdy), 32'd1);

        // Timeout in HIGH.
        cyc(0, 0, 8'h00, 1);
        cyc(0, 1, 8'h21, 0);
        fe_cnt = 0;
        for (int i = 1; i <= int'(TO) + 1; i++) begin
            cyc(0, 0, 8'h00, 0);
            chk_model();
            if (bus.frame_err) fe_cnt++;
        end
        chk("fe_count_high", 32'(fe_cnt), 32'd1);

        // Third byte lands exactly on the expiry cycle: accept wins.
        cyc(0, 1, 8'h11, 0);
        cyc(0, 1, 8'h22, 0);
        fe_cnt = 0;
        for (int i = 1; i < int'(TO); i++) begin
            cyc(0, 0, 8'h00, 0);
            if (bus.frame_err) fe_cnt++;
        end
        cyc(0, 1, 8'h33, 0);
        chk("tie.frame_err", 32'(bus.frame_err), 32'd0);
        chk("tie.fe_count", 32'(fe_cnt), 32'd0);
        chk("tie.cmd", 32'(bus.cmd), 32'h11);
        chk("tie.data", 32'(bus.data), 32'h2233);
        chk("tie.rdy", 32'(bus.cmd_rdy), 32'd1);
        cyc(0, 0, 8'h00, 0);
        chk_model();

        // Randomized traffic with occasional near-timeout gaps and resets.
        for (int n = 0; n < 200; n++) begin
            int unsigned gap;
            gap = ($urandom % 8 == 0) ? (TO - 5 + $urandom % 8) : ($urandom % 4);
            for (int unsigned g = 0; g < gap; g++) begin
                cyc(0, 0, 8'($urandom), ($urandom % 4) == 0);
                chk_model();
            end
            cyc(($urandom % 64) == 0, 1'b1, 8'($urandom), ($urandom % 4) == 0);
            chk_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
